// File: rtl/bti_arb2_if.sv
// BTI request/response channel bundle shared by the two masters and the slave port of bti_arb2.
interface bti_arb2_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  logic            req_vld;
  logic            req_rdy;
  logic [AW-1:0]   req_addr;
  logic            req_wr;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_wstrb;
  logic            rsp_vld;
  logic            rsp_rdy;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  // Request issuer: drives the request, consumes the response.
  modport master (
    output req_vld, req_addr, req_wr, req_wdata, req_wstrb, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata, rsp_err
  );

  // Request target: consumes the request, drives the response.
  modport slave (
    input  req_vld, req_addr, req_wr, req_wdata, req_wstrb, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/bti_arb2.sv
// Two-master to one-slave BTI arbiter: round-robin grant held while the slave stalls,
// plus an in-order id FIFO that steers each slave response back to its issuing master.
module bti_arb2 #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned OST = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  bti_arb2_if.slave  m0,
  bti_arb2_if.slave  m1,
  bti_arb2_if.master s
);

  localparam int unsigned PW = (OST > 1) ? $clog2(OST) : 1;
  localparam int unsigned CW = $clog2(OST + 1);
  localparam int unsigned SW = DW / 8;

  typedef enum logic [0:0] {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic           lock_id_q, lock_id_d;
  logic           last_q, last_d;
  logic [OST-1:0] id_q, id_d;
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic          empty_c, head_c, rsp_rdy_c, pop_c, full_blk_c;
  logic          any_c, grant_c, req_vld_c, push_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wdata_c;
  logic [SW-1:0] wstrb_c;
  logic          wr_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OST - 1)) ? '0 : p + PW'(1);
  endfunction

  // Grant, flow-control and response steering.
  always_comb begin
    empty_c    = (cnt_q == '0);
    head_c     = id_q[rptr_q];
    rsp_rdy_c  = !empty_c && (head_c ? m1.rsp_rdy : m0.rsp_rdy);
    pop_c      = s.rsp_vld && rsp_rdy_c;
    full_blk_c = (cnt_q == CW'(OST)) && !pop_c;
    any_c      = m0.req_vld || m1.req_vld;
    grant_c    = m1.req_vld;
    if (state_q == ST_LOCKED) begin
      grant_c = lock_id_q;
    end else if (m0.req_vld && m1.req_vld) begin
      grant_c = !last_q;
    end
    req_vld_c = any_c && !full_blk_c;
    push_c    = req_vld_c && s.req_rdy;
    addr_c    = grant_c ? m1.req_addr  : m0.req_addr;
    wr_c      = grant_c ? m1.req_wr    : m0.req_wr;
    wdata_c   = grant_c ? m1.req_wdata : m0.req_wdata;
    wstrb_c   = grant_c ? m1.req_wstrb : m0.req_wstrb;
  end

  // Next state: lock tracking, round-robin history and id FIFO.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    last_d    = last_q;
    id_d      = id_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q + CW'(push_c) - CW'(pop_c);
    if (state_q == ST_OPEN) begin
      if (req_vld_c && !s.req_rdy) begin
        state_d   = ST_LOCKED;
        lock_id_d = grant_c;
      end
    end else if (push_c) begin
      state_d = ST_OPEN;
    end
    if (push_c) begin
      id_d[wptr_q] = grant_c;
      wptr_d       = ptr_inc(wptr_q);
      last_d       = grant_c;
    end
    if (pop_c) begin
      rptr_d = ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_OPEN;
      lock_id_q <= 1'b0;
      last_q    <= 1'b1;
      id_q      <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
      id_q      <= id_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s.req_vld   = req_vld_c;
  assign s.req_addr  = addr_c;
  assign s.req_wr    = wr_c;
  assign s.req_wdata = wdata_c;
  assign s.req_wstrb = wstrb_c;
  assign s.rsp_rdy   = rsp_rdy_c;

  // Ready only reaches a master that is actually requesting and holds the grant.
  assign m0.req_rdy = req_vld_c && !grant_c && s.req_rdy;
  assign m1.req_rdy = req_vld_c &&  grant_c && s.req_rdy;

  assign m0.rsp_vld   = s.rsp_vld && !empty_c && !head_c;
  assign m1.rsp_vld   = s.rsp_vld && !empty_c &&  head_c;
  assign m0.rsp_rdata = s.rsp_rdata;
  assign m1.rsp_rdata = s.rsp_rdata;
  assign m0.rsp_err   = s.rsp_err;
  assign m1.rsp_err   = s.rsp_err;

  // A response with no outstanding id has no owner and would stall forever.
  a_rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n) !(s.rsp_vld && empty_c));

endmodule

// File: tb/tb_bti_arb2.sv
// Bench for bti_arb2: directed scenarios with fixed expectations, then randomized traffic
// checked against a queue-based model of the arbitration and routing rules.
module tb_bti_arb2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned OST = 2;

  logic clk;
  logic rst_n;
  int   npass;
  int   ntotal;

  bti_arb2_if #(.AW(AW), .DW(DW)) m0_if ();
  bti_arb2_if #(.AW(AW), .DW(DW)) m1_if ();
  bti_arb2_if #(.AW(AW), .DW(DW)) s_if ();

  bti_arb2 #(.AW(AW), .DW(DW), .OST(OST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic idle();
    m0_if.req_vld = 0; m0_if.req_addr = '0; m0_if.req_wr = 0; m0_if.req_wdata = '0; m0_if.req_wstrb = '0; m0_if.rsp_rdy = 0;
    m1_if.req_vld = 0; m1_if.req_addr = '0; m1_if.req_wr = 0; m1_if.req_wdata = '0; m1_if.req_wstrb = '0; m1_if.rsp_rdy = 0;
    s_if.req_rdy = 0; s_if.rsp_vld = 0; s_if.rsp_rdata = '0; s_if.rsp_err = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    s_if.req_rdy = 1; m0_if.rsp_rdy = 1; m1_if.rsp_rdy = 1;
    #1;
    ntotal++; if (s_if.req_vld !== 1'b0) $display("FAIL reset_s_req_vld got=%0b exp=0", s_if.req_vld); else npass++;
    ntotal++; if (m0_if.req_rdy !== 1'b0) $display("FAIL reset_m0_req_rdy got=%0b exp=0", m0_if.req_rdy); else npass++;
    ntotal++; if (m1_if.req_rdy !== 1'b0) $display("FAIL reset_m1_req_rdy got=%0b exp=0", m1_if.req_rdy); else npass++;
    ntotal++; if (m0_if.rsp_vld !== 1'b0) $display("FAIL reset_m0_rsp_vld got=%0b exp=0", m0_if.rsp_vld); else npass++;
    ntotal++; if (m1_if.rsp_vld !== 1'b0) $display("FAIL reset_m1_rsp_vld got=%0b exp=0", m1_if.rsp_vld); else npass++;
    ntotal++; if (s_if.rsp_rdy !== 1'b0) $display("FAIL reset_s_rsp_rdy got=%0b exp=0", s_if.rsp_rdy); else npass++;
    idle();
  endtask

  task automatic test_single();
    do_reset();
    m0_if.req_vld = 1; m0_if.req_addr = 32'h100; m0_if.req_wr = 0; s_if.req_rdy = 1;
    #1;
    ntotal++; if (s_if.req_vld !== 1'b1) $display("FAIL single_s_req_vld got=%0b exp=1", s_if.req_vld); else npass++;
    ntotal++; if (s_if.req_addr !== 32'h100) $display("FAIL single_addr got=%0h exp=100", s_if.req_addr); else npass++;
    ntotal++; if (m0_if.req_rdy !== 1'b1) $display("FAIL single_m0_rdy got=%0b exp=1", m0_if.req_rdy); else npass++;
    ntotal++; if (m1_if.req_rdy !== 1'b0) $display("FAIL single_m1_rdy got=%0b exp=0", m1_if.req_rdy); else npass++;
    tick();
    m0_if.req_vld = 0;
    #1;
    ntotal++; if (s_if.req_vld !== 1'b0) $display("FAIL single_idle_vld got=%0b exp=0", s_if.req_vld); else npass++;
    ntotal++; if (m1_if.rsp_vld !== 1'b0) $display("FAIL single_wait_m1_rsp got=%0b exp=0", m1_if.rsp_vld); else npass++;
    tick();
    s_if.rsp_vld = 1; s_if.rsp_rdata = 32'hDEADBEEF; m0_if.rsp_rdy = 1;
    #1;
    ntotal++; if (m0_if.rsp_vld !== 1'b1) $display("FAIL single_m0_rsp_vld got=%0b exp=1", m0_if.rsp_vld); else npass++;
    ntotal++; if (m0_if.rsp_rdata !== 32'hDEADBEEF) $display("FAIL single_rdata got=%0h exp=deadbeef", m0_if.rsp_rdata); else npass++;
    ntotal++; if (m1_if.rsp_vld !== 1'b0) $display("FAIL single_m1_rsp_vld got=%0b exp=0", m1_if.rsp_vld); else npass++;
    ntotal++; if (s_if.rsp_rdy !== 1'b1) $display("FAIL single_s_rsp_rdy got=%0b exp=1", s_if.rsp_rdy); else npass++;
    tick();
    idle();
  endtask

  task automatic test_tie();
    bit g, h;
    do_reset();
    m0_if.req_vld = 1; m0_if.req_addr = 32'h200;
    m1_if.req_vld = 1; m1_if.req_addr = 32'h300;
    s_if.req_rdy = 1; m0_if.rsp_rdy = 1; m1_if.rsp_rdy = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin m0_if.req_vld = 0; m1_if.req_vld = 0; end
      s_if.rsp_vld = (k >= 1);
      s_if.rsp_rdata = 32'hA000_0000 + 32'(k);
      #1;
      if (k < 4) begin
        g = 1'(k % 2);
        ntotal++; if (m0_if.req_rdy !== !g) $display("FAIL tie_m0_rdy k=%0d got=%0b exp=%0b", k, m0_if.req_rdy, !g); else npass++;
        ntotal++; if (m1_if.req_rdy !== g) $display("FAIL tie_m1_rdy k=%0d got=%0b exp=%0b", k, m1_if.req_rdy, g); else npass++;
        ntotal++; if (s_if.req_addr !== (g ? 32'h300 : 32'h200)) $display("FAIL tie_addr k=%0d got=%0h", k, s_if.req_addr); else npass++;
      end
      if (k >= 1) begin
        h = 1'((k - 1) % 2);
        ntotal++; if (m0_if.rsp_vld !== !h) $display("FAIL tie_m0_rsp k=%0d got=%0b exp=%0b", k, m0_if.rsp_vld, !h); else npass++;
        ntotal++; if (m1_if.rsp_vld !== h) $display("FAIL tie_m1_rsp k=%0d got=%0b exp=%0b", k, m1_if.rsp_vld, h); else npass++;
      end
      tick();
    end
    idle();
  endtask

  task automatic test_lock();
    do_reset();
    m1_if.req_vld = 1; m1_if.req_addr = 32'h340; m0_if.req_addr = 32'h140;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) m0_if.req_vld = 1;
      if (k == 4) m1_if.req_vld = 0;
      s_if.req_rdy = (k >= 3);
      #1;
      if (k <= 3) begin
        ntotal++; if (s_if.req_addr !== 32'h340) $display("FAIL lock_addr k=%0d got=%0h exp=340", k, s_if.req_addr); else npass++;
        ntotal++; if (m0_if.req_rdy !== 1'b0) $display("FAIL lock_m0_rdy k=%0d got=%0b exp=0", k, m0_if.req_rdy); else npass++;
        ntotal++; if (m1_if.req_rdy !== (k == 3)) $display("FAIL lock_m1_rdy k=%0d got=%0b", k, m1_if.req_rdy); else npass++;
      end else begin
        ntotal++; if (m0_if.req_rdy !== 1'b1) $display("FAIL lock_after_m0_rdy got=%0b exp=1", m0_if.req_rdy); else npass++;
        ntotal++; if (s_if.req_addr !== 32'h140) $display("FAIL lock_after_addr got=%0h exp=140", s_if.req_addr); else npass++;
      end
      tick();
    end
    idle();
  endtask

  task automatic test_full();
    do_reset();
    m0_if.req_vld = 1; m0_if.req_addr = 32'h180; s_if.req_rdy = 1; m0_if.rsp_rdy = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      ntotal++; if (m0_if.req_rdy !== 1'b1) $display("FAIL full_fill_rdy k=%0d got=%0b exp=1", k, m0_if.req_rdy); else npass++;
      tick();
    end
    m1_if.req_vld = 1; m1_if.req_addr = 32'h380;
    #1;
    ntotal++; if (s_if.req_vld !== 1'b0) $display("FAIL full_blk_vld got=%0b exp=0", s_if.req_vld); else npass++;
    ntotal++; if (m0_if.req_rdy !== 1'b0 || m1_if.req_rdy !== 1'b0) $display("FAIL full_blk_rdy got=%0b%0b exp=00", m0_if.req_rdy, m1_if.req_rdy); else npass++;
    tick();
    s_if.rsp_vld = 1; s_if.rsp_rdata = 32'h55;
    #1;
    ntotal++; if (m0_if.rsp_vld !== 1'b1 || s_if.rsp_rdy !== 1'b1) $display("FAIL full_pop got=%0b%0b exp=11", m0_if.rsp_vld, s_if.rsp_rdy); else npass++;
    ntotal++; if (s_if.req_vld !== 1'b1) $display("FAIL full_pop_vld got=%0b exp=1", s_if.req_vld); else npass++;
    ntotal++; if (m1_if.req_rdy !== 1'b1) $display("FAIL full_pop_m1_rdy got=%0b exp=1", m1_if.req_rdy); else npass++;
    tick();
    s_if.rsp_vld = 0; m1_if.req_vld = 0;
    #1;
    ntotal++; if (s_if.req_vld !== 1'b0) $display("FAIL full_still_vld got=%0b exp=0", s_if.req_vld); else npass++;
    tick();
    idle();
  endtask

  task automatic test_backpressure();
    do_reset();
    s_if.req_rdy = 1;
    m0_if.req_vld = 1; m0_if.req_addr = 32'h1C0;
    #1;
    ntotal++; if (m0_if.req_rdy !== 1'b1) $display("FAIL bp_m0_accept got=%0b exp=1", m0_if.req_rdy); else npass++;
    tick();
    m0_if.req_vld = 0; m1_if.req_vld = 1; m1_if.req_addr = 32'h3C0;
    #1;
    ntotal++; if (m1_if.req_rdy !== 1'b1) $display("FAIL bp_m1_accept got=%0b exp=1", m1_if.req_rdy); else npass++;
    tick();
    m1_if.req_vld = 0; s_if.rsp_vld = 1; s_if.rsp_rdata = 32'hA5A5_0001; m0_if.rsp_rdy = 0; m1_if.rsp_rdy = 1;
    for (int j = 0; j < 2; j++) begin
      #1;
      ntotal++; if (m0_if.rsp_vld !== 1'b1 || m1_if.rsp_vld !== 1'b0) $display("FAIL bp_stall_route j=%0d got=%0b%0b exp=10", j, m0_if.rsp_vld, m1_if.rsp_vld); else npass++;
      ntotal++; if (s_if.rsp_rdy !== 1'b0) $display("FAIL bp_stall_rdy j=%0d got=%0b exp=0", j, s_if.rsp_rdy); else npass++;
      tick();
    end
    m0_if.rsp_rdy = 1;
    #1;
    ntotal++; if (s_if.rsp_rdy !== 1'b1 || m0_if.rsp_vld !== 1'b1) $display("FAIL bp_release got=%0b%0b exp=11", s_if.rsp_rdy, m0_if.rsp_vld); else npass++;
    ntotal++; if (m0_if.rsp_rdata !== 32'hA5A5_0001) $display("FAIL bp_rdata0 got=%0h exp=a5a50001", m0_if.rsp_rdata); else npass++;
    tick();
    s_if.rsp_rdata = 32'h5A5A_0002; s_if.rsp_err = 1; m0_if.rsp_rdy = 0;
    #1;
    ntotal++; if (m1_if.rsp_vld !== 1'b1 || m0_if.rsp_vld !== 1'b0) $display("FAIL bp_m1_route got=%0b%0b exp=10", m1_if.rsp_vld, m0_if.rsp_vld); else npass++;
    ntotal++; if (s_if.rsp_rdy !== 1'b1) $display("FAIL bp_m1_rdy got=%0b exp=1", s_if.rsp_rdy); else npass++;
    ntotal++; if (m1_if.rsp_rdata !== 32'h5A5A_0002 || m1_if.rsp_err !== 1'b1) $display("FAIL bp_m1_data got=%0h/%0b exp=5a5a0002/1", m1_if.rsp_rdata, m1_if.rsp_err); else npass++;
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_if.req_rdy = 1; m0_if.req_vld = 1; m0_if.req_addr = 32'h1E0;
    tick();
    tick();
    s_if.req_rdy = 0; m0_if.req_vld = 0; m1_if.req_vld = 1; m1_if.req_addr = 32'h3E0;
    s_if.rsp_vld = 1; m0_if.rsp_rdy = 1;
    #1;
    ntotal++; if (s_if.req_vld !== 1'b1 || s_if.req_addr !== 32'h3E0) $display("FAIL rmid_stall got=%0b/%0h exp=1/3e0", s_if.req_vld, s_if.req_addr); else npass++;
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m0_if.req_vld = 1; m0_if.req_addr = 32'h1E4; m1_if.req_vld = 1; m1_if.req_addr = 32'h3E4; s_if.req_rdy = 1;
    #1;
    ntotal++; if (m0_if.req_rdy !== 1'b1 || m1_if.req_rdy !== 1'b0) $display("FAIL rmid_first_tie got=%0b%0b exp=10", m0_if.req_rdy, m1_if.req_rdy); else npass++;
    tick();
    #1;
    ntotal++; if (m1_if.req_rdy !== 1'b1) $display("FAIL rmid_second got=%0b exp=1", m1_if.req_rdy); else npass++;
    tick();
    #1;
    ntotal++; if (s_if.req_vld !== 1'b0) $display("FAIL rmid_full got=%0b exp=0", s_if.req_vld); else npass++;
    tick();
    idle();
  endtask

  task automatic test_random();
    bit          mq[$];
    bit          mlast, mlock, mlockid;
    bit          pend[2];
    logic [31:0] ma[2], md[2];
    logic        mw[2];
    logic [3:0]  ms[2];
    bit          spend, serr, r0, r1, sreq;
    logic [31:0] sdata;
    bit          head, p_srdy, p_pop, any, g, blk, p_svld;
    do_reset();
    mq.delete(); mlast = 1; mlock = 0; mlockid = 0;
    pend[0] = 0; pend[1] = 0; spend = 0; serr = 0; sdata = '0;
    for (int i = 0; i < 2; i++) begin ma[i] = '0; md[i] = '0; mw[i] = 0; ms[i] = '0; end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1; ma[i] = $urandom(); md[i] = $urandom(); mw[i] = 1'($urandom_range(0, 1)); ms[i] = 4'($urandom());
        end
      end
      if (!spend && mq.size() > 0 && $urandom_range(0, 2) != 0) begin
        spend = 1; sdata = $urandom(); serr = 1'($urandom_range(0, 1));
      end
      r0 = ($urandom_range(0, 3) != 0); r1 = ($urandom_range(0, 3) != 0); sreq = ($urandom_range(0, 2) != 0);
      m0_if.req_vld = pend[0]; m0_if.req_addr = ma[0]; m0_if.req_wr = mw[0]; m0_if.req_wdata = md[0]; m0_if.req_wstrb = ms[0]; m0_if.rsp_rdy = r0;
      m1_if.req_vld = pend[1]; m1_if.req_addr = ma[1]; m1_if.req_wr = mw[1]; m1_if.req_wdata = md[1]; m1_if.req_wstrb = ms[1]; m1_if.rsp_rdy = r1;
      s_if.req_rdy = sreq; s_if.rsp_vld = spend; s_if.rsp_rdata = sdata; s_if.rsp_err = serr;
      #1;
      head   = (mq.size() > 0) ? mq[0] : 1'b0;
      p_srdy = (mq.size() > 0) && (head ? r1 : r0);
      p_pop  = spend && p_srdy;
      any    = pend[0] || pend[1];
      g      = mlock ? mlockid : ((pend[0] && pend[1]) ? !mlast : pend[1]);
      blk    = (mq.size() == OST) && !p_pop;
      p_svld = any && !blk;
      ntotal++; if (s_if.req_vld !== p_svld) $display("FAIL rnd_s_req_vld c=%0d got=%0b exp=%0b", c, s_if.req_vld, p_svld); else npass++;
      ntotal++; if (m0_if.req_rdy !== (p_svld && !g && sreq)) $display("FAIL rnd_m0_rdy c=%0d got=%0b", c, m0_if.req_rdy); else npass++;
      ntotal++; if (m1_if.req_rdy !== (p_svld && g && sreq)) $display("FAIL rnd_m1_rdy c=%0d got=%0b", c, m1_if.req_rdy); else npass++;
      ntotal++; if (s_if.rsp_rdy !== p_srdy) $display("FAIL rnd_s_rsp_rdy c=%0d got=%0b exp=%0b", c, s_if.rsp_rdy, p_srdy); else npass++;
      ntotal++; if (m0_if.rsp_vld !== (spend && mq.size() > 0 && !head)) $display("FAIL rnd_m0_rsp_vld c=%0d got=%0b", c, m0_if.rsp_vld); else npass++;
      ntotal++; if (m1_if.rsp_vld !== (spend && mq.size() > 0 && head)) $display("FAIL rnd_m1_rsp_vld c=%0d got=%0b", c, m1_if.rsp_vld); else npass++;
      if (p_svld) begin
        ntotal++;
        if (s_if.req_addr !== ma[g] || s_if.req_wdata !== md[g] || s_if.req_wr !== mw[g] || s_if.req_wstrb !== ms[g])
          $display("FAIL rnd_payload c=%0d got=%0h/%0h/%0b/%0h exp=%0h/%0h/%0b/%0h", c, s_if.req_addr, s_if.req_wdata, s_if.req_wr, s_if.req_wstrb, ma[g], md[g], mw[g], ms[g]);
        else npass++;
      end
      if (spend) begin
        ntotal++;
        if (m0_if.rsp_rdata !== sdata || m1_if.rsp_rdata !== sdata || m0_if.rsp_err !== serr || m1_if.rsp_err !== serr)
          $display("FAIL rnd_rsp_data c=%0d got=%0h/%0h exp=%0h", c, m0_if.rsp_rdata, m1_if.rsp_rdata, sdata);
        else npass++;
      end
      if (p_pop) begin void'(mq.pop_front()); spend = 0; end
      if (p_svld && sreq) begin
        mq.push_back(g); mlast = g; mlock = 0; pend[g] = 0;
      end else if (p_svld) begin
        mlock = 1; mlockid = g;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    npass = 0;
    ntotal = 0;
    rst_n = 1'b0;
    idle();
    test_reset();
    test_single();
    test_tie();
    test_lock();
    test_full();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/bti_arb2.md
Name: bti_arb2

Overview:
- Two-master to one-slave BTI arbiter. Shares a single TCM port between the fetch path (master 0) and the load/store path (master 1).
- Used when ITCM and DTCM are merged into one unified TCM behind the biu.
- Round-robin grant with a grant lock while the slave stalls.
- An in-order routing FIFO steers each response back to the master that issued the request.

Parameters:
- AW, 32, address width.
- DW, 32, data width; the byte-strobe width is DW/8.
- OST, 2, maximum outstanding requests (routing FIFO depth, >=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- m0_req_vld  in  1  master 0 request valid
- m0_req_rdy  out  1  master 0 request ready
- m0_req_addr  in  AW  master 0 address
- m0_req_wr  in  1  master 0 write (1) / read (0)
- m0_req_wdata  in  DW  master 0 write data
- m0_req_wstrb  in  DW/8  master 0 byte strobes
- m0_rsp_vld  out  1  master 0 response valid
- m0_rsp_rdy  in  1  master 0 response ready
- m0_rsp_rdata  out  DW  master 0 read data
- m0_rsp_err  out  1  master 0 response error
- m1_*: same set as m0_*, for master 1.
- s_req_vld  out  1  slave request valid
- s_req_rdy  in  1  slave request ready
- s_req_addr  out  AW  slave address
- s_req_wr  out  1  slave write (1) / read (0)
- s_req_wdata  out  DW  slave write data
- s_req_wstrb  out  DW/8  slave byte strobes
- s_rsp_vld  in  1  slave response valid
- s_rsp_rdy  out  1  slave response ready
- s_rsp_rdata  in  DW  slave read data
- s_rsp_err  in  1  slave response error

Behaviour:
- Handshake: a transfer occurs when vld&&rdy in the same cycle. A master holds vld and payload stable until accepted. The slave answers requests in order.
- Request path is combinational (zero added latency): s_req_* = payload of the granted master. s_req_vld = (any request) && !fifo_full_blk.
  - fifo_full_blk = (count==OST) && !(s_rsp_vld&&s_rsp_rdy).
  - A pop in the same cycle frees a slot.
- Ready: mX_req_rdy = granted(X) && s_req_rdy && !fifo_full_blk. The ungranted master sees rdy=0.
- Arbitration:
  - One requester: that master is granted.
  - Both requesting: the master != last_winner is granted.
  - last_winner updates only on an accepted slave request.
  - Reset value of last_winner = 1, so master 0 wins the first tie.
- Lock: if s_req_vld=1 && s_req_rdy=0, register lock=1 and lock_id=grant. While locked the grant is forced to lock_id, regardless of the other master. lock clears on acceptance.
- Routing FIFO: OST entries of 1-bit master id.
  - Push the grant id on an accepted slave request; pop on an accepted slave response.
  - Push and pop in the same cycle is legal at any count, including full.
  - Read/write pointers wrap modulo OST. count is 0..OST.
- Response path is combinational: the FIFO head selects the target.
  - m<head>_rsp_vld = s_rsp_vld && !empty. The other master's rsp_vld = 0.
  - s_rsp_rdy = m<head>_rsp_rdy && !empty.
  - rdata and err are broadcast to both masters; they are qualified only by rsp_vld.
- s_rsp_vld with an empty FIFO: s_rsp_rdy=0, no master valid, response stalls (protocol violation; an assertion flags it).
- Reset (sync, rst_n=0 at posedge):
  - count=0, pointers=0, lock=0, last_winner=1.
  - Combinationally, all *_vld/*_rdy outputs are 0 while count=0 and there are no requests.
  - Reset mid-transaction discards outstanding ids; the slave must be reset in the same cycle.
- No internal request buffering; the block holds no data, only ids.

Test Plan:
1. Single master: m0 read addr 0x100, s_req_rdy=1, slave responds rdata 0xDEADBEEF 2 cycles later -> s_req_addr=0x100 same cycle; m0_rsp_vld with 0xDEADBEEF; m1_rsp_vld=0 throughout.
2. Tie after reset: m0 and m1 request continuously, slave always ready -> grants alternate 0,1,0,1 over 4 accepts; the FIFO id order matches, and each response reaches the correct master.
3. Lock: m1 granted, s_req_rdy=0 for 3 cycles, m0 raises vld in cycle 2 -> grant stays on m1, s_req_addr stable; m0 is granted the cycle after m1 is accepted.
4. Full FIFO: OST=2, two accepts with no response -> s_req_vld=0 and both req_rdy=0. Next cycle response pop plus new request -> accepted that same cycle, count stays 2.
5. Response backpressure: head=m0, m0_rsp_rdy=0 for 2 cycles -> s_rsp_rdy=0, FIFO unchanged; pop when m0_rsp_rdy=1; a following m1 response is routed to m1.
6. Reset with 2 outstanding and lock=1 -> next cycle count=0, lock=0; the first tie is granted to m0.
